vision_test_ctrl: RTL and testbench
===================================

VISION_TEST_CTRL -- requirements
Module: vision_test_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 20: cycles a raw button level must stay stable before it is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 5000: response window in cycles, counted from entry to WAIT_RESP.
REQ-003 Parameter TRIALS, default 4: trials per level.
REQ-004 Parameter PASS_MIN, default 3: correct answers needed to advance a level.
REQ-005 Parameter LEVELS, default 8: level count, 0..LEVELS-1.
REQ-006 clk1  in  1: system clock. Reset is rst, asynchronous, active-high; clock is clk1.
REQ-007 rst  in  1: asynchronous active-high reset.
REQ-008 start  in  1: raw start button, active-high, not synchronised.
REQ-009 btn  in  4: raw direction buttons, active-high; bit0 right, bit1 up, bit2 left, bit3 down.
REQ-010 dir  out  2: displayed optotype orientation, fed to the lattice driver; 0 right, 1 up, 2 left, 3 down.
REQ-011 show  out  1: high while the optotype is displayed.
REQ-012 level  out  3: current level.
REQ-013 hit, miss  out  1 each: one-cycle judgement pulses.
REQ-014 done  out  1: test finished; level holds the final result.

Function
REQ-015 start and btn SHALL pass through a 2-flop synchroniser and a DEB_CYC debouncer; only rising edges of the debounced signal are events.
REQ-016 Orientation source SHALL be an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed 8'hA5, stepped every cycle and never all-zero.
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_RESP, JUDGE, NEXT and DONE.
REQ-018 IDLE -> LOAD on a start event; level, trial count and correct count SHALL clear to 0 on this transition.
REQ-019 LOAD (1 cycle): cand = lfsr[1:0]; dir <= (cand == previous dir) ? cand+1 mod 4 : cand; then -> WAIT_RESP and clear the timeout counter.
REQ-020 WAIT_RESP: show = 1. Any button event, or the counter reaching TIMEOUT_CYC-1, SHALL move the FSM -> JUDGE on the next cycle.
REQ-021 A response is correct only if exactly one debounced btn edge occurs in the decision cycle and its index equals dir; multiple simultaneous edges or a timeout SHALL count as wrong.
REQ-022 JUDGE (1 cycle): show = 0; assert exactly one of hit or miss; increment the correct count on hit; increment the trial count; then -> NEXT.
REQ-023 NEXT: if trial count < TRIALS -> LOAD; else if correct >= PASS_MIN and level < LEVELS-1 -> level+1, clear the counts, -> LOAD; else -> DONE.
REQ-024 Final level: on a pass at LEVELS-1, level SHALL stay at LEVELS-1. On a fail, level SHALL be decremented, saturating at 0.
REQ-025 DONE: done = 1, show = 0; outputs hold until a start event -> IDLE-equivalent restart (same clears as REQ-018).
REQ-026 start events outside IDLE and DONE SHALL be ignored; button events outside WAIT_RESP SHALL be ignored.
REQ-027 Counters SHALL be wide enough for their parameters and SHALL NOT wrap.

Reset
REQ-028 On rst the FSM SHALL enter IDLE, with dir = 0, show = 0, level = 0, hit = miss = done = 0, lfsr = 8'hA5, and debouncers cleared to not-pressed.
REQ-029 rst asserted mid-trial SHALL abort immediately, with no hit/miss pulse on release.

Structure
REQ-030 A shared package SHALL hold the state enum, direction encodings (DIR_RIGHT..DIR_DOWN), LFSR seed and taps.
REQ-031 A single sub-module, debounce, SHALL be instantiated 5 times (start plus 4 btn).

Verification
REQ-032 Start, then answer each displayed dir correctly for 4 trials -> 4 hit pulses, level 0 -> 1, show re-asserts within 2 cycles.
REQ-033 At level 2, answer 2 right and 2 wrong -> done = 1, level = 1; a second failing run at level 0 ends with level = 0.
REQ-034 No press for TIMEOUT_CYC cycles -> miss exactly TIMEOUT_CYC+1 cycles after WAIT_RESP entry.
REQ-035 Correct and wrong buttons pressed in the same cycle -> miss. A 10-cycle glitch with DEB_CYC = 20 -> no event.
REQ-036 30 consecutive LOADs -> dir never equals the previous dir. rst pulse in WAIT_RESP -> IDLE, show = 0, no hit/miss.

Source files
------------

// File: rtl/vision_test_ctrl_pkg.sv
// Shared types and constants for the visual-acuity test controller.
// Holds the FSM state encoding, optotype directions and the LFSR definition.
package vision_test_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RESP,
    JUDGE,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// rise pulses for one cycle when the accepted level goes from released to pressed.
module debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // The new level is taken once it has differed from the accepted one for DEB_CYC cycles
  assign accept = (sync != stable) && (cnt == CW'(DEB_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      rise <= accept & sync;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vision_test_ctrl.sv
// Visual-acuity test sequencer: shows a random optotype orientation, judges the
// debounced button answer, and walks the level up or down over trial blocks.
module vision_test_ctrl #(
  parameter int DEB_CYC     = 20,
  parameter int TIMEOUT_CYC = 5000,
  parameter int TRIALS      = 4,
  parameter int PASS_MIN    = 3,
  parameter int LEVELS      = 8
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [1:0] dir,
  output logic       show,
  output logic [2:0] level,
  output logic       hit,
  output logic       miss,
  output logic       done
);

  import vision_test_ctrl_pkg::*;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int NW = $clog2(TRIALS + 1);

  logic          start_ev;
  logic [3:0]    btn_ev;
  logic [7:0]    lfsr;
  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [NW-1:0] trial_cnt;
  logic [NW-1:0] correct_cnt;
  logic          verdict;
  logic          tmo_hit;
  logic          pass;

  logic          clr_all;
  logic          clr_cnt;
  logic          do_load;
  logic          decide;
  logic          do_judge;
  logic          lvl_up;
  logic          lvl_down;

  // Correct only when the single edge present is the one matching the shown direction
  function automatic logic single_match(input logic [3:0] ev, input logic [1:0] d);
    return ev == (4'b0001 << d);
  endfunction

  debounce #(.DEB_CYC(DEB_CYC)) u_start (
    .clk  (clk1),
    .rst  (rst),
    .raw  (start),
    .rise (start_ev)
  );

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce #(.DEB_CYC(DEB_CYC)) u_btn (
      .clk  (clk1),
      .rst  (rst),
      .raw  (btn[i]),
      .rise (btn_ev[i])
    );
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_step(lfsr);
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign pass    = int'(correct_cnt) >= PASS_MIN;
  assign show    = (state == WAIT_RESP);
  assign done    = (state == DONE);
  assign clr_cnt = clr_all | lvl_up;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_all   = 1'b0;
    do_load   = 1'b0;
    decide    = 1'b0;
    do_judge  = 1'b0;
    lvl_up    = 1'b0;
    lvl_down  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_ev) begin
          clr_all   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if ((btn_ev != 4'b0000) || tmo_hit) begin
          decide    = 1'b1;
          state_nxt = JUDGE;
        end
      end
      JUDGE: begin
        do_judge  = 1'b1;
        state_nxt = NEXT;
      end
      NEXT: begin
        if (int'(trial_cnt) < TRIALS) begin
          state_nxt = LOAD;
        end else if (pass && (level < 3'(LEVELS - 1))) begin
          lvl_up    = 1'b1;
          state_nxt = LOAD;
        end else begin
          lvl_down  = ~pass;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      dir         <= DIR_RIGHT;
      level       <= 3'd0;
      trial_cnt   <= '0;
      correct_cnt <= '0;
      tmo_cnt     <= '0;
      verdict     <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
    end else begin
      hit  <= do_judge & verdict;
      miss <= do_judge & ~verdict;

      if (clr_all) begin
        level <= 3'd0;
      end else if (lvl_up) begin
        level <= level + 3'd1;
      end else if (lvl_down && (level != 3'd0)) begin
        level <= level - 3'd1;
      end

      // Never repeat the previous orientation: bump the candidate by one quadrant
      if (do_load) begin
        dir     <= (lfsr[1:0] == dir) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
        tmo_cnt <= '0;
      end else if ((state == WAIT_RESP) && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (decide) verdict <= single_match(btn_ev, dir);

      if (clr_cnt) begin
        trial_cnt   <= '0;
        correct_cnt <= '0;
      end else if (do_judge) begin
        if (int'(trial_cnt) < TRIALS) trial_cnt <= trial_cnt + NW'(1);
        if (verdict && (int'(correct_cnt) < TRIALS)) correct_cnt <= correct_cnt + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vision_test_ctrl.sv
// Directed bench for vision_test_ctrl: table-driven trial run plus hand sequences
// for timeout latency, glitch rejection, mid-trial reset and a long run to the top level.
module tb_vision_test_ctrl;

  localparam int DEB = 20;
  localparam int TMO = 5000;
  localparam int K_OK    = 0;
  localparam int K_WRONG = 1;
  localparam int K_BOTH  = 2;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] btn;
  logic [1:0] dir;
  logic       show;
  logic [2:0] level;
  logic       hit;
  logic       miss;
  logic       done;

  vision_test_ctrl #(
    .DEB_CYC(DEB), .TIMEOUT_CYC(TMO), .TRIALS(4), .PASS_MIN(3), .LEVELS(8)
  ) dut (
    .clk1  (clk1),
    .rst   (rst),
    .start (start),
    .btn   (btn),
    .dir   (dir),
    .show  (show),
    .level (level),
    .hit   (hit),
    .miss  (miss),
    .done  (done)
  );

  always #5 clk1 = ~clk1;

  // Reference LFSR; m_prev holds the value the DUT saw during the previous cycle
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;
  always @(posedge clk1 or posedge rst) begin
    if (rst) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_prev <= m_lfsr;
    end
  end

  typedef struct {
    logic       start_first;
    int         kind;
    logic       exp_hit;
    logic [2:0] exp_level;
    logic       exp_done;
  } vec_t;

  vec_t tbl [16];

  int         checks = 0;
  int         failures = 0;
  logic       show_last = 1'b0;
  logic       rise_flag = 1'b0;
  logic [7:0] rise_lfsr = 8'h00;
  logic [1:0] prev_dir = 2'd0;
  logic [1:0] cur_dir = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk1);
    if (show === 1'b1 && !show_last) begin
      rise_flag = 1'b1;
      rise_lfsr = m_prev;
    end
    show_last = (show === 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_show();
    logic [1:0] e;
    int n = 0;
    while (!rise_flag && n < 200) begin
      tick();
      n++;
    end
    if (!rise_flag) begin
      chk("show_rise_timeout", 32'd0, 32'd1);
    end else begin
      e = rise_lfsr[1:0];
      if (e == prev_dir) e = e + 2'd1;
      chk("dir", {30'd0, dir}, {30'd0, e});
      chk("dir_not_repeated", {31'd0, dir != prev_dir}, 32'd1);
      prev_dir = e;
      cur_dir  = e;
    end
    rise_flag = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      tick();
      n++;
      if (hit === 1'b1 || miss === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [3:0] mask_of(input int kind, input logic [1:0] d);
    logic [3:0] good;
    logic [3:0] bad;
    good = 4'b0001 << d;
    bad  = 4'b0001 << (d + 2'd1);
    case (kind)
      K_OK:    return good;
      K_WRONG: return bad;
      default: return good | bad;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   pulses;
    int   highs;
    logic ok;

    tbl[0]  = '{1'b1, K_OK,    1'b1, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, K_OK,    1'b1, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, K_OK,    1'b1, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, K_OK,    1'b1, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, K_OK,    1'b1, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, K_OK,    1'b1, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, K_OK,    1'b1, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, K_OK,    1'b1, 3'd2, 1'b0};
    tbl[8]  = '{1'b0, K_OK,    1'b1, 3'd2, 1'b0};
    tbl[9]  = '{1'b0, K_OK,    1'b1, 3'd2, 1'b0};
    tbl[10] = '{1'b0, K_WRONG, 1'b0, 3'd2, 1'b0};
    tbl[11] = '{1'b0, K_BOTH,  1'b0, 3'd1, 1'b1};
    tbl[12] = '{1'b1, K_WRONG, 1'b0, 3'd0, 1'b0};
    tbl[13] = '{1'b0, K_BOTH,  1'b0, 3'd0, 1'b0};
    tbl[14] = '{1'b0, K_WRONG, 1'b0, 3'd0, 1'b0};
    tbl[15] = '{1'b0, K_WRONG, 1'b0, 3'd0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    btn   = 4'b0000;
    ticks(3);
    chk("rst_dir",   {30'd0, dir},   32'd0);
    chk("rst_show",  {31'd0, show},  32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_pulse", {31'd0, hit | miss}, 32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    rst = 1'b0;
    ticks(2);

    // Table run: level 0 -> 1 -> 2, fail at 2 -> 1, then a failing restart at 0
    for (int t = 0; t < 16; t++) begin
      if (tbl[t].start_first) start = 1'b1;
      wait_show();
      start = 1'b0;
      btn = mask_of(tbl[t].kind, cur_dir);
      wait_pulse(200, n, ok);
      if (ok) begin
        chk("judge_hit",  {31'd0, hit},  {31'd0, tbl[t].exp_hit});
        chk("judge_miss", {31'd0, miss}, {31'd0, ~tbl[t].exp_hit});
      end
      btn = 4'b0000;
      tick();
      chk("pulse_one_cycle", {31'd0, hit | miss}, 32'd0);
      tick();
      chk("trial_level", {29'd0, level}, {29'd0, tbl[t].exp_level});
      chk("trial_done",  {31'd0, done},  {31'd0, tbl[t].exp_done});
      chk("trial_show",  {31'd0, show},  {31'd0, ~tbl[t].exp_done});
      ticks(DEB + 4);
    end

    // Timeout: miss arrives TMO+1 cycles after show rises
    start = 1'b1;
    wait_show();
    start = 1'b0;
    wait_pulse(TMO + 100, n, ok);
    chk("timeout_latency", n, TMO + 1);
    chk("timeout_miss", {31'd0, miss}, 32'd1);
    chk("timeout_hit",  {31'd0, hit},  32'd0);

    // 10-cycle glitch on the correct button must not register
    wait_show();
    btn = mask_of(K_OK, cur_dir);
    ticks(10);
    btn = 4'b0000;
    pulses = 0;
    for (int i = 0; i < DEB + 10; i++) begin
      tick();
      if (hit === 1'b1 || miss === 1'b1) pulses++;
    end
    chk("glitch_no_event", pulses, 0);
    chk("glitch_show_held", {31'd0, show}, 32'd1);
    btn = mask_of(K_OK, cur_dir);
    wait_pulse(200, n, ok);
    chk("after_glitch_hit", {31'd0, hit}, 32'd1);
    btn = 4'b0000;
    ticks(DEB + 4);

    // Reset in the middle of WAIT_RESP aborts without a judgement
    wait_show();
    ticks(5);
    btn = mask_of(K_OK, cur_dir);
    rst = 1'b1;
    tick();
    chk("midrst_show",  {31'd0, show},  32'd0);
    chk("midrst_dir",   {30'd0, dir},   32'd0);
    chk("midrst_pulse", {31'd0, hit | miss}, 32'd0);
    tick();
    rst = 1'b0;
    prev_dir  = 2'd0;
    rise_flag = 1'b0;
    show_last = 1'b0;
    pulses = 0;
    highs  = 0;
    for (int i = 0; i < DEB + 20; i++) begin
      tick();
      if (hit === 1'b1 || miss === 1'b1) pulses++;
      if (show === 1'b1) highs++;
    end
    btn = 4'b0000;
    chk("midrst_no_pulse", pulses, 0);
    chk("midrst_idle_show", highs, 0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    ticks(DEB + 4);

    // 32 correct trials: every LOAD changes dir, level climbs and holds at the top
    start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_show();
      start = 1'b0;
      btn = mask_of(K_OK, cur_dir);
      wait_pulse(200, n, ok);
      chk("run_hit", {31'd0, hit}, 32'd1);
      btn = 4'b0000;
      ticks(DEB + 4);
      if (i % 4 == 3) chk("run_level", {29'd0, level}, (i + 1) / 4 > 7 ? 32'd7 : (i + 1) / 4);
    end
    chk("top_done", {31'd0, done}, 32'd1);
    chk("top_show", {31'd0, show}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
